// File: rtl/mips_boot_loader_pkg.sv
// Shared types and constants for the MIPS byte-stream boot loader.
package mips_boot_loader_pkg;

  // Loader states: length header, payload words, checksum byte, core running, load rejected.
  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  // Number of big-endian bytes in the word-count header.
  localparam int LEN_BYTES = 2;

  // Starting value of the running payload XOR.
  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/mips_boot_loader_packer.sv
// Byte-to-word assembler: shifts payload bytes into a word, counts bytes
// within the word and keeps the running XOR of every payload byte.
module boot_word_packer
  import mips_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic        word_last_byte,
  output logic [7:0]  csum
);

  // Only the three older bytes are stored; the 4th byte completes the word
  // combinationally so the write can be registered on the same edge.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;

  // Next-state: clear wins over accept; stalls hold everything.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
      csum_d  = CSUM_INIT;
    end else if (accept) begin
      shift_d = {shift_q[15:0], data_in};
      cnt_d   = cnt_q + 2'd1;
      csum_d  = csum_q ^ data_in;
    end
  end

  // Packer registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= CSUM_INIT;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign word           = {shift_q, data_in};
  assign word_last_byte = accept & ~clear & (cnt_q == 2'd3);
  assign csum           = csum_q;

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: parses the length/payload/checksum byte stream, writes
// instruction memory one word at a time and releases the core's reset
// only after a checksum-verified image is in place.
module mips_boot_loader
  import mips_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // Largest legal word count; index is one bit wider so it can reach it.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic                len_cnt_q, len_cnt_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wd_q, wd_d;

  logic                xfer;
  logic                reload_ok;
  logic                pk_clear;
  logic                pk_accept;
  logic [31:0]         pk_word;
  logic                pk_last;
  logic [7:0]          pk_csum;
  logic [15:0]         full_n;
  logic [ADDR_W:0]     idx_next;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer      = in_valid & in_ready;
  assign reload_ok = reload & ((state_q == S_RUN) || (state_q == S_ERR));
  assign pk_clear  = (state_q == S_LEN) | reload_ok;
  assign pk_accept = xfer & (state_q == S_DATA);
  assign full_n    = {n_q[15:8], in_data};
  assign idx_next  = idx_q + 1'b1;

  boot_word_packer u_packer (
    .clk            (clk),
    .reset          (reset),
    .clear          (pk_clear),
    .accept         (pk_accept),
    .data_in        (in_data),
    .word           (pk_word),
    .word_last_byte (pk_last),
    .csum           (pk_csum)
  );

  // FSM next-state, word-index counter and write-port next values.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    len_cnt_d = len_cnt_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wd_d      = wd_q;
    unique case (state_q)
      S_LEN: begin
        if (xfer) begin
          if (len_cnt_q != 1'(LEN_BYTES - 1)) begin
            n_d[15:8] = in_data;
            len_cnt_d = 1'b1;
          end else begin
            n_d       = full_n;
            len_cnt_d = 1'b0;
            idx_d     = '0;
            if ({1'b0, full_n} > CAPACITY) state_d = S_ERR;
            else if (full_n == 16'd0)      state_d = S_CSUM;
            else                           state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_last) begin
          we_d   = 1'b1;
          addr_d = idx_q[ADDR_W-1:0];
          wd_d   = pk_word;
          idx_d  = idx_next;
          if (16'(idx_next) == n_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (in_data == pk_csum) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d   = S_LEN;
          n_d       = '0;
          len_cnt_d = 1'b0;
          idx_d     = '0;
        end
      end
      default: state_d = S_LEN;
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LEN;
      n_q       <= '0;
      len_cnt_q <= 1'b0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      len_cnt_q <= len_cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  // Status decoded from the registered state, so reset forces cpu_reset high asynchronously.
  assign cpu_reset = (state_q != S_RUN);
  assign done      = (state_q == S_RUN);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized scoreboard bench for mips_boot_loader: the stimulus side pushes
// the writes a stream should produce, an independent monitor pops and
// compares every imem_we pulse.
module tb_mips_boot_loader;

  localparam int ADDR_W = 6;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_reset;
  logic              done;
  logic              error;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h with nothing expected", imem_addr, imem_wd);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(w.a));
        chk("wr_data", imem_wd, w.d);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Offer one byte, with random idle cycles first; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int guard;
    guard = 0;
    while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1) begin
      guard++;
      if (guard > 50) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic expect_final(input bit run);
    chk("done", 32'(done), 32'(run));
    chk("error", 32'(error), 32'(!run));
    chk("cpu_reset", 32'(cpu_reset), 32'(!run));
    chk("in_ready_final", 32'(in_ready), 32'd0);
  endtask

  task automatic expect_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wd", imem_wd, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  // Full stream: header n, n words, checksum = payload XOR ^ cs_flip.
  task automatic run_stream(input logic [15:0] n, input logic [31:0] words[$],
                            input logic [7:0] cs_flip, input int stall);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    if (int'(n) > CAP) begin
      send_byte(n[15:8], stall);
      send_byte(n[7:0], stall);
      expect_final(1'b0);
      return;
    end
    for (int i = 0; i < int'(n); i++) exp_q.push_back('{a: ADDR_W'(i), d: words[i]});
    send_byte(n[15:8], stall);
    send_byte(n[7:0], stall);
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[31-8*b -: 8], stall);
        x ^= w[31-8*b -: 8];
      end
    end
    send_byte(x ^ cs_flip, stall);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    expect_final(cs_flip == 8'h00);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_error", 32'(error), 32'd0);
  endtask

  function automatic void rand_words(output logic [31:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endfunction

  initial begin
    logic [31:0] ws[$];
    logic [31:0] w0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    // Good load from the worked example; checksum byte is 08.
    ws = '{32'h20020005, 32'h2003000C};
    run_stream(16'd2, ws, 8'h00, 0);
    do_reload();

    // Same stream with checksum 09: writes happen, load rejected.
    run_stream(16'd2, ws, 8'h01, 0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_in_ready", 32'(in_ready), 32'd0);
      chk("err_hold", 32'(error), 32'd1);
    end
    in_valid = 1'b0;
    do_reload();

    // Empty image: good (00) and bad (5A) checksum.
    ws = {};
    run_stream(16'd0, ws, 8'h00, 0);
    do_reload();
    run_stream(16'd0, ws, 8'h5A, 0);
    do_reload();

    // Overflow headers, including one with a nonzero high byte.
    run_stream(16'h0041, ws, 8'h00, 0);
    do_reload();
    run_stream(16'h0100, ws, 8'h00, 0);
    do_reload();

    // Good load with random stalls.
    ws = '{32'h20020005, 32'h2003000C};
    run_stream(16'd2, ws, 8'h00, 40);
    do_reload();

    // Reset after 5 payload bytes: only word 0 is written.
    rand_words(ws, 2);
    w0 = ws[0];
    exp_q.push_back('{a: '0, d: w0});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int b = 0; b < 4; b++) send_byte(w0[31-8*b -: 8], 30);
    send_byte(ws[1][31:24], 0);
    reset = 1'b1;
    #1;
    expect_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    chk("midload_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rand_words(ws, 3);
    run_stream(16'd3, ws, 8'h00, 20);
    do_reload();

    // Maximum image size.
    rand_words(ws, CAP);
    run_stream(16'(CAP), ws, 8'h00, 25);
    do_reload();

    // Random short loads with random checksum corruption.
    for (int t = 0; t < 6; t++) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(1, 8);
      flip = ($urandom_range(1) == 0) ? 8'h00 : 8'(1 << $urandom_range(7));
      rand_words(ws, n);
      run_stream(16'(n), ws, flip, 30);
      do_reload();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Byte-stream program loader that writes the instruction memory of the single-cycle MIPS core and holds the core in reset until a complete, checksum-verified image is in place. It is the writer side of the instruction-memory read port. It sits between an external byte source (UART receiver or testbench) and a write port added to the instruction memory. It drives the core's reset: the core only fetches from address 0 after a good load.

## Interface
- ADDR_W, 6: instruction-memory word-address width; capacity 2^ADDR_W words.
- clk  in  1  system clock; reset asynchronous, active-high.
- reset  in  1  asynchronous, active-high; returns the block to S_LEN.
- in_valid  in  1  byte-source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- reload  in  1  single-cycle request to start a new load; honoured only in S_RUN or S_ERR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wd  out  32  word to write.
- cpu_reset  out  1  reset to the MIPS core; high except in S_RUN.
- done  out  1  image loaded and verified.
- error  out  1  load rejected (length overflow or checksum mismatch).

## Operation
- Stream format, all multi-byte fields big-endian:
  - 16-bit word count N.
  - 4·N payload bytes; the first byte of each word is bits 31:24.
  - 1 checksum byte, equal to the XOR of all payload bytes. The length bytes are excluded.
- **S_LEN**: accept 2 bytes into N.
  - N > 2^ADDR_W → S_ERR.
  - N == 0 → S_CSUM.
  - Otherwise → S_DATA with word index 0 and byte count 0.
- **S_DATA**: accept bytes, shift them into a 32-bit assembly register and XOR them into the running checksum.
  - On the 4th byte of a word, issue a write of the assembled word to the current index, then increment the index.
  - After word N−1 → S_CSUM.
- **S_CSUM**: accept 1 byte.
  - Equal to the running checksum → S_RUN.
  - Otherwise → S_ERR.
- **S_RUN**: in_ready=0, cpu_reset=0, done=1.
  - reload → S_LEN. Index, byte count, checksum and N are cleared; done drops.
- **S_ERR**: in_ready=0, cpu_reset=1, error=1.
  - reload → S_LEN. error drops.
- reload is ignored in S_LEN, S_DATA and S_CSUM.
- Stalls: cycles with in_valid=0 change nothing. in_data is not sampled when no transfer occurs.
- Reset values: state=S_LEN, in_ready=1, imem_we=0, imem_addr=0, imem_wd=0, cpu_reset=1, done=0, error=0. Index, count and checksum are all 0.
- Reset mid-load: the load is abandoned. Words already written stay in memory. The next stream starts from a fresh length.
- Width rules:
  - The index is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal.
  - imem_addr is the low ADDR_W bits of the index.
  - The byte count is 2 bits and wraps 3→0 on each word.

## Timing
- in_ready is decoded from the registered state: 1 in S_LEN, S_DATA and S_CSUM; 0 in S_RUN and S_ERR.
- imem_we, imem_addr and imem_wd are registered. imem_we is high for exactly the one cycle after the 4th byte of a word is accepted.
- Throughput is one byte per cycle, so back-to-back words give a write every 4 cycles.
- The checksum byte cannot be accepted earlier than the cycle after the last payload byte. The final write therefore completes no later than the checksum acceptance.
- done, error and cpu_reset update in the cycle after the deciding byte (checksum byte, or 2nd length byte for overflow).
- reload → S_LEN in the cycle after it is sampled. cpu_reset rises and in_ready rises in that same cycle.
- cpu_reset is forced high asynchronously by reset.

## Structure
- The shared package holds:
  - the state enum: S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR;
  - LEN_BYTES=2;
  - CSUM_INIT=8'h00.
- One sub-module, boot_word_packer: the byte shift register, byte counter and XOR accumulator. Its inputs are clear and accept. Its outputs are word, word_last_byte and csum.
- The FSM, index counter and write-port registers live in mips_boot_loader.
- The instruction memory gains a synchronous write port (we, wa, wd) on clk. Its read path is unchanged.

## Test plan
- **Good load.** Stream 00 02 | 20 02 00 05 | 20 03 00 0C | 08 → writes addr0=0x20020005 and addr1=0x2003000C. One cycle after the 08 byte, done=1 and cpu_reset=0.
- **Checksum mismatch.** Same stream with a final byte of 09 → both writes still occur. Then error=1, cpu_reset stays 1, in_ready=0, and further bytes are not accepted.
- **Empty image.** 00 00 | 00 → S_RUN with no imem_we pulses. Length 00 00 with checksum 5A → S_ERR.
- **Overflow, ADDR_W=6.** Length 00 41 → error=1 the cycle after the 2nd byte; zero writes.
- **Stalls and reset mid-load.** in_valid toggles randomly during the good load → identical writes. Assert reset after 5 payload bytes → all outputs return to reset values, and a following good load succeeds.
- **Full load and reload.** From S_RUN, pulse reload → cpu_reset=1 and in_ready=1 the next cycle. Then load N=64 (00 40) → 64 writes, the last at addr 63, and done=1.
